// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: byte-serial CRC32 step, FCS mapping and RX FSM states.
package eth_pkg;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam int FCS_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } rx_state_e;

  // Register is kept MSB-first; data bits enter LSB first as on the wire.
  function automatic logic [31:0] eth_crc32_next(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0] eth_fcs(input logic [31:0] crc);
    logic [31:0] f;
    for (int i = 0; i < 32; i++) begin
      f[i] = ~crc[31-i];
    end
    return f;
  endfunction

endpackage

// File: rtl/eth_byte_delay4.sv
// Four-deep byte shift register; sr[3] is the oldest byte, sr[0] the newest.
module eth_byte_delay4
  import eth_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [7:0]                 din,
  output logic [7:0]                 oldest,
  output logic [FCS_BYTES-1:0][7:0]  sr,
  output logic [2:0]                 count
);

  assign oldest = sr[FCS_BYTES-1];

  // A push during clr starts a fresh frame, so occupancy restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        sr <= {sr[FCS_BYTES-2:0], din};
      end
      if (clr) begin
        count <= push ? 3'd1 : 3'd0;
      end else if (push && (count != 3'(FCS_BYTES))) begin
        count <= count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker: strips the 4 trailing FCS bytes, re-checks CRC32, reports status and stats.
// Streams are valid-only: a byte moves whenever its valid is high, there is no backpressure.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_data,
  input  logic             i_vl,
  input  logic             i_frame,
  output logic [7:0]       o_data,
  output logic             o_vl,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic             o_short,
  output logic [CNT_W-1:0] o_len,
  output logic [CNT_W-1:0] o_frames,
  output logic [CNT_W-1:0] o_errors
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_e                state, state_next;
  logic                     i_frame_d;
  logic [31:0]              crc;
  logic [CNT_W-1:0]         len;
  logic                     push, clr, emit, eof;
  logic                     ok_c, short_c;
  logic [7:0]               oldest;
  logic [FCS_BYTES-1:0][7:0] sr;
  logic [2:0]               count;

  eth_byte_delay4 u_delay (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .push   (push),
    .din    (i_data),
    .oldest (oldest),
    .sr     (sr),
    .count  (count)
  );

  always_comb begin
    state_next = state;
    push       = 1'b0;
    clr        = 1'b0;
    emit       = 1'b0;
    eof        = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (i_frame && !i_frame_d) begin
          push       = i_vl;
          state_next = FILL;
        end
      end
      FILL: begin
        if (!i_frame) begin
          eof        = 1'b1;
          state_next = IDLE;
        end else if (i_vl) begin
          push = 1'b1;
          if (count == 3'(FCS_BYTES - 1)) state_next = RUN;
        end
      end
      RUN: begin
        if (!i_frame) begin
          eof        = 1'b1;
          state_next = IDLE;
        end else if (i_vl) begin
          push = 1'b1;
          emit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Delay line holds the received FCS with the first-arrived byte in sr[3].
  always_comb begin
    short_c = 1'b1;
    ok_c    = 1'b0;
    if (state == RUN) begin
      short_c = (len < CNT_W'(MIN_PAYLOAD));
      ok_c    = !short_c && ({sr[0], sr[1], sr[2], sr[3]} == eth_fcs(crc));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_frame_d <= 1'b1;
      crc       <= CRC_INIT;
      len       <= '0;
      o_data    <= '0;
      o_vl      <= 1'b0;
      o_done    <= 1'b0;
      o_crc_ok  <= 1'b0;
      o_short   <= 1'b0;
      o_len     <= '0;
      o_frames  <= '0;
      o_errors  <= '0;
    end else begin
      state     <= state_next;
      i_frame_d <= i_frame;
      o_vl      <= emit;
      o_done    <= eof;
      if (emit) o_data <= oldest;
      if (state == IDLE) begin
        crc <= CRC_INIT;
        len <= '0;
      end else if (emit) begin
        crc <= eth_crc32_next(oldest, crc);
        if (len != CNT_MAX) len <= len + 1'b1;
      end
      if (eof) begin
        o_crc_ok <= ok_c;
        o_short  <= short_c;
        o_len    <= (state == RUN) ? len : '0;
        if (o_frames != CNT_MAX) o_frames <= o_frames + 1'b1;
        if (!ok_c && (o_errors != CNT_MAX)) o_errors <= o_errors + 1'b1;
      end else begin
        o_crc_ok <= 1'b0;
        o_short  <= 1'b0;
        o_len    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check using the "123456789" CRC32 check frame.
`timescale 1ns/1ps
module tb_eth_rx_fcs_check;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       i_data = '0;
  logic             i_vl = 1'b0;
  logic             i_frame = 1'b0;
  logic [7:0]       o_data;
  logic             o_vl, o_done, o_crc_ok, o_short;
  logic [CNT_W-1:0] o_len, o_frames, o_errors;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frm_q[$];

  eth_rx_fcs_check #(.MIN_PAYLOAD(1), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .i_vl     (i_vl),
    .i_frame  (i_frame),
    .o_data   (o_data),
    .o_vl     (o_vl),
    .o_done   (o_done),
    .o_crc_ok (o_crc_ok),
    .o_short  (o_short),
    .o_len    (o_len),
    .o_frames (o_frames),
    .o_errors (o_errors)
  );

  // Clock / collector
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_vl === 1'b1) got_q.push_back(o_data);
    if (o_done === 1'b1) done_cnt++;
  end

  // Driver tasks and checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_good();
    logic [7:0] pay[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    frm_q.delete();
    exp_q.delete();
    foreach (pay[i]) begin
      frm_q.push_back(pay[i]);
      exp_q.push_back(pay[i]);
    end
    frm_q.push_back(8'h26);
    frm_q.push_back(8'h39);
    frm_q.push_back(8'hF4);
    frm_q.push_back(8'hCB);
  endtask

  // Drives frm_q; when now_first is set the first byte goes out at the current negedge.
  task automatic drive_frame(input bit alt_vl, input bit now_first);
    got_q.delete();
    foreach (frm_q[i]) begin
      if (!(now_first && i == 0)) @(negedge clk);
      i_frame = 1'b1;
      if (alt_vl) begin
        i_vl = 1'b0;
        @(negedge clk);
      end
      i_vl   = 1'b1;
      i_data = frm_q[i];
    end
    @(negedge clk);
    i_frame = 1'b0;
    i_vl    = 1'b0;
  endtask

  task automatic check_done(input string tag, input bit ok, input bit sh,
                            input int len, input int frames, input int errors);
    chk({tag, ".done"}, 32'(o_done), 32'd1);
    chk({tag, ".ok"}, 32'(o_crc_ok), 32'(ok));
    chk({tag, ".short"}, 32'(o_short), 32'(sh));
    chk({tag, ".len"}, 32'(o_len), 32'(len));
    chk({tag, ".frames"}, 32'(o_frames), 32'(frames));
    chk({tag, ".errors"}, 32'(o_errors), 32'(errors));
  endtask

  task automatic check_data(input string tag);
    chk({tag, ".nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      chk($sformatf("%s.byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx,
          32'(exp_q[i]));
    end
  endtask

  initial begin
    int done_before;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.o_vl", 32'(o_vl), 32'd0);
    chk("reset.o_done", 32'(o_done), 32'd0);
    chk("reset.o_frames", 32'(o_frames), 32'd0);
    chk("reset.o_errors", 32'(o_errors), 32'd0);
    chk("reset.o_len", 32'(o_len), 32'd0);

    // good frame
    load_good();
    drive_frame(1'b0, 1'b0);
    @(negedge clk);
    check_done("good", 1'b1, 1'b0, 9, 1, 0);
    check_data("good");
    @(negedge clk);
    chk("good.pulse_one_cycle", 32'(o_done), 32'd0);

    // corrupted last FCS byte
    load_good();
    frm_q[12] = 8'hCA;
    drive_frame(1'b0, 1'b0);
    @(negedge clk);
    check_done("badfcs", 1'b0, 1'b0, 9, 2, 1);
    check_data("badfcs");

    // good frame with i_vl on alternate cycles
    load_good();
    drive_frame(1'b1, 1'b0);
    @(negedge clk);
    check_done("alt", 1'b1, 1'b0, 9, 3, 1);
    check_data("alt");

    // runt frame of three bytes
    frm_q = '{8'hAA, 8'hBB, 8'hCC};
    exp_q.delete();
    drive_frame(1'b0, 1'b0);
    @(negedge clk);
    check_done("runt", 1'b0, 1'b1, 0, 4, 2);
    check_data("runt");

    // reset in the middle of a frame, released while i_frame is still high
    @(negedge clk);
    load_good();
    done_before = done_cnt;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      i_frame = 1'b1;
      i_vl    = 1'b1;
      i_data  = frm_q[i];
      if (i == 5) rst = 1'b1;
      if (i == 7) begin
        rst = 1'b0;
        got_q.delete();
      end
    end
    @(negedge clk);
    i_frame = 1'b0;
    i_vl    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid.no_done", 32'(done_cnt), 32'(done_before));
    chk("rstmid.no_bytes", 32'(got_q.size()), 32'd0);
    chk("rstmid.frames", 32'(o_frames), 32'd0);
    chk("rstmid.errors", 32'(o_errors), 32'd0);
    drive_frame(1'b0, 1'b0);
    @(negedge clk);
    check_done("after_rst", 1'b1, 1'b0, 9, 1, 0);
    check_data("after_rst");

    // two good frames separated by a single i_frame-low cycle
    @(negedge clk);
    drive_frame(1'b0, 1'b0);
    @(negedge clk);
    check_done("b2b_a", 1'b1, 1'b0, 9, 2, 0);
    check_data("b2b_a");
    drive_frame(1'b0, 1'b1);
    @(negedge clk);
    check_done("b2b_b", 1'b1, 1'b0, 9, 3, 0);
    check_data("b2b_b");

    repeat (3) @(negedge clk);
    chk("total_done_pulses", 32'(done_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
